// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the adder vector checker.
package adder_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2011;

    localparam logic MODE_EXH = 1'b0;
    localparam logic MODE_RND = 1'b1;

endpackage

// File: rtl/adder_vector_checker_if.sv
// Operand/result bus between the checker and the adder under test.
interface adder_vector_checker_if #(parameter int N = 8);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s_duv;
    logic         cout_duv;

    modport master (output a, b, cin, input s_duv, cout_duv);
    modport slave  (input a, b, cin, output s_duv, cout_duv);
endinterface

// File: rtl/adder_chk_lfsr.sv
// Galois LFSR exposing STEPS successive words; one advance consumes all of them.
module adder_chk_lfsr
    import adder_chk_pkg::*;
#(
    parameter int             W     = 32,
    parameter logic [W-1:0]   TAPS  = W'(LFSR_TAPS),
    parameter logic [W-1:0]   SEED  = W'(DEFAULT_SEED),
    parameter int             STEPS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               advance,
    output logic [STEPS*W-1:0] words
);

    logic [W-1:0] state;
    logic [W-1:0] nxt;

    function automatic logic [W-1:0] step(input logic [W-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // words[0] is the current state, words[k] the k-th successor
    always_comb begin
        words = '0;
        nxt   = state;
        for (int k = 0; k < STEPS; k++) begin
            words[k*W +: W] = nxt;
            nxt = step(nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          state <= SEED;
        else if (advance) state <= nxt;
    end

endmodule

// File: rtl/adder_vector_checker.sv
// Vector generator and latency-aligned golden compare for adder regression.
module adder_vector_checker
    import adder_chk_pkg::*;
#(
    parameter int          N          = 8,
    parameter int          LATENCY    = 0,
    parameter int          NUM_RANDOM = 30000,
    parameter logic [31:0] SEED       = DEFAULT_SEED,
    parameter int          CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    adder_vector_checker_if.master duv,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      vec_count,
    output logic [CNT_W-1:0]      err_count,
    output logic [N-1:0]          fail_a,
    output logic [N-1:0]          fail_b,
    output logic                  fail_cin
);

    localparam int WPO   = (N + 31) / 32;
    localparam int WORDS = 2 * WPO + 1;
    localparam bit EXH_OK = (N <= 12);
    localparam int ENT_W = 3 * N + 2;

    state_t           state;
    logic             mode_rnd;
    logic [2*N:0]     exh_cnt;
    logic [31:0]      rnd_rem;
    logic [3:0]       drain_cnt;
    logic [N-1:0]     a_q, b_q;
    logic             cin_q, valid_q, first_seen;

    logic [WORDS*32-1:0] lfsr_words;
    logic                lfsr_unused;
    logic [WPO*32-1:0]   a_w, b_w;
    logic [N-1:0]        a_nxt, b_nxt;
    logic                cin_nxt, last;

    adder_chk_lfsr #(.W(32), .TAPS(LFSR_TAPS), .SEED(SEED), .STEPS(WORDS)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (state == RUN && mode_rnd),
        .words   (lfsr_words)
    );

    assign lfsr_unused = ^lfsr_words;
    assign a_w = lfsr_words[0 +: WPO*32];
    assign b_w = lfsr_words[WPO*32 +: WPO*32];

    always_comb begin
        if (mode_rnd) begin
            a_nxt   = a_w[N-1:0];
            b_nxt   = b_w[N-1:0];
            cin_nxt = lfsr_words[2*WPO*32];
            last    = (rnd_rem == '0);
        end else begin
            {cin_nxt, b_nxt, a_nxt} = exh_cnt;
            last = &exh_cnt;
        end
    end

    // Golden result travels with its operands so a mismatch can be attributed
    logic [N:0]       sum_ref;
    logic [ENT_W-1:0] cur_ent, del_ent;
    logic             del_v;

    assign sum_ref = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
    assign cur_ent = {sum_ref, cin_q, b_q, a_q};

    generate
        if (LATENCY == 0) begin : g_nodelay
            assign del_ent = cur_ent;
            assign del_v   = valid_q;
        end else begin : g_delay
            logic [ENT_W-1:0] sr_ent [LATENCY];
            logic             sr_v   [LATENCY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        sr_ent[i] <= '0;
                        sr_v[i]   <= 1'b0;
                    end
                end else begin
                    sr_ent[0] <= cur_ent;
                    sr_v[0]   <= valid_q;
                    for (int i = 1; i < LATENCY; i++) begin
                        sr_ent[i] <= sr_ent[i-1];
                        sr_v[i]   <= sr_v[i-1];
                    end
                end
            end
            assign del_ent = sr_ent[LATENCY-1];
            assign del_v   = sr_v[LATENCY-1];
        end
    endgenerate

    logic mismatch;
    assign mismatch = del_v && ({duv.cout_duv, duv.s_duv} != del_ent[ENT_W-1 -: N+1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mode_rnd   <= 1'b0;
            exh_cnt    <= '0;
            rnd_rem    <= '0;
            drain_cnt  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            valid_q    <= 1'b0;
            first_seen <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_cin   <= 1'b0;
        end else begin
            valid_q <= (state == RUN);
            if (del_v) begin
                vec_count <= vec_count + 1'b1;
                if (mismatch) begin
                    if (~&err_count) err_count <= err_count + 1'b1;
                    if (!first_seen) begin
                        first_seen <= 1'b1;
                        fail_a     <= del_ent[N-1:0];
                        fail_b     <= del_ent[2*N-1:N];
                        fail_cin   <= del_ent[2*N];
                    end
                end
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state      <= RUN;
                    mode_rnd   <= (mode == MODE_RND) || !EXH_OK;
                    exh_cnt    <= '0;
                    rnd_rem    <= 32'(NUM_RANDOM - 1);
                    busy       <= 1'b1;
                    done       <= 1'b0;
                    vec_count  <= '0;
                    err_count  <= '0;
                    fail_a     <= '0;
                    fail_b     <= '0;
                    fail_cin   <= 1'b0;
                    first_seen <= 1'b0;
                end
                RUN: begin
                    a_q     <= a_nxt;
                    b_q     <= b_nxt;
                    cin_q   <= cin_nxt;
                    exh_cnt <= exh_cnt + 1'b1;
                    rnd_rem <= rnd_rem - 1'b1;
                    if (last) begin
                        state     <= DRAIN;
                        drain_cnt <= 4'(LATENCY);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pass  = done && (err_count == '0);
    assign duv.a   = a_q;
    assign duv.b   = b_q;
    assign duv.cin = cin_q;

endmodule
